// File: rtl/multimode_ring_counter.sv
// Purpose: one-hot ring / Johnson counter with selectable width, mode, direction, seed load and illegal-state self-correction.
// Latency: one clock from override, load or en to the new count; wrap and illegal are registered on the same edge.
// Backpressure: none; en=0 holds the state, and every enabled edge produces a new count.
module multimode_ring_counter #(
  parameter int WIDTH = 4  // counter width in bits, WIDTH >= 2
) (
  input  logic             clk,
  input  logic             override,  // synchronous active-low reset
  input  logic             en,
  input  logic             mode,      // 0 = ring, 1 = Johnson
  input  logic             dir,       // 0 = toward MSB, 1 = toward LSB
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             illegal
);

  // Ring legality: exactly one bit set.
  function automatic logic ring_ok(input logic [WIDTH-1:0] v);
    int ones;
    ones = 0;
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) ones++;
    end
    return (ones == 1);
  endfunction

  // Johnson legality: at most one adjacent-bit transition (0^a1^b or 1^a0^b).
  function automatic logic johnson_ok(input logic [WIDTH-1:0] v);
    int edges;
    edges = 0;
    for (int i = 0; i < WIDTH - 1; i++) begin
      if (v[i] ^ v[i+1]) edges++;
    end
    return (edges <= 1);
  endfunction

  logic [WIDTH-1:0] home_st;
  logic [WIDTH-1:0] step_val;
  logic             legal;

  // Home state, legality of the current count and the next step, all under the current mode.
  // Mode is not stored, so a mode change is caught by the legality check on the next enabled edge.
  always_comb begin
    home_st  = mode ? '0 : {{(WIDTH-1){1'b0}}, 1'b1};
    legal    = mode ? johnson_ok(count) : ring_ok(count);
    step_val = count;
    case ({mode, dir})
      2'b00:   step_val = {count[WIDTH-2:0], count[WIDTH-1]};
      2'b01:   step_val = {count[0], count[WIDTH-1:1]};
      2'b10:   step_val = {count[WIDTH-2:0], ~count[WIDTH-1]};
      default: step_val = {~count[0], count[WIDTH-1:1]};
    endcase
  end

  // State register: override > load > enabled step (with correction) > hold; flags are one-cycle pulses.
  always_ff @(posedge clk) begin
    if (!override) begin
      count   <= home_st;
      wrap    <= 1'b0;
      illegal <= 1'b0;
    end else if (load) begin
      count   <= seed;
      wrap    <= 1'b0;
      illegal <= 1'b0;
    end else if (en) begin
      if (!legal) begin
        count   <= home_st;
        wrap    <= 1'b0;
        illegal <= 1'b1;
      end else begin
        count   <= step_val;
        wrap    <= (step_val == home_st);
        illegal <= 1'b0;
      end
    end else begin
      wrap    <= 1'b0;
      illegal <= 1'b0;
    end
  end

endmodule

// File: tb/tb_multimode_ring_counter.sv
// Purpose: randomized plus directed stimulus against a sequence-table reference model, scoreboard-checked.
// Latency: expected response is queued when inputs are driven and checked after the following rising edge.
// Backpressure: none; the DUT presents a new output every clock.
module tb_multimode_ring_counter;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         override = 1'b0;
  logic         en = 1'b0;
  logic         mode = 1'b0;
  logic         dir = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] seed = '0;
  logic [W-1:0] count;
  logic         wrap;
  logic         illegal;

  int checks = 0;
  int failures = 0;

  // expected {count, wrap, illegal}
  logic [W+1:0] sb[$];

  logic [W-1:0] m_count;

  multimode_ring_counter #(.WIDTH(W)) dut (
    .clk(clk), .override(override), .en(en), .mode(mode), .dir(dir),
    .load(load), .seed(seed), .count(count), .wrap(wrap), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // k-th state of the legal sequence starting at home, stepping toward the MSB.
  function automatic logic [W-1:0] seq_state(input logic md, input int k);
    if (!md) return W'(1 << k);
    if (k <= W) return W'((1 << k) - 1);
    return W'(((1 << W) - 1) ^ ((1 << (k - W)) - 1));
  endfunction

  // Position of v within the legal sequence, -1 if v is not a legal state.
  function automatic int seq_index(input logic md, input logic [W-1:0] v);
    int period;
    period = md ? 2 * W : W;
    for (int k = 0; k < period; k++) begin
      if (seq_state(md, k) == v) return k;
    end
    return -1;
  endfunction

  // Apply one edge worth of inputs and queue the response the model predicts.
  task automatic drive(input logic ov, input logic ld, input logic e,
                       input logic md, input logic dr, input logic [W-1:0] sd);
    int period;
    int idx;
    logic w;
    logic il;
    @(negedge clk);
    override = ov; load = ld; en = e; mode = md; dir = dr; seed = sd;
    period = md ? 2 * W : W;
    w = 1'b0;
    il = 1'b0;
    if (!ov) begin
      m_count = seq_state(md, 0);
    end else if (ld) begin
      m_count = sd;
    end else if (e) begin
      idx = seq_index(md, m_count);
      if (idx < 0) begin
        m_count = seq_state(md, 0);
        il = 1'b1;
      end else begin
        idx = dr ? (idx + period - 1) % period : (idx + 1) % period;
        m_count = seq_state(md, idx);
        w = (idx == 0);
      end
    end
    sb.push_back({m_count, w, il});
  endtask

  // Monitor: compare every presented output against the oldest queued expectation.
  always @(posedge clk) begin
    logic [W+1:0] exp;
    #1;
    if (sb.size() > 0) begin
      exp = sb.pop_front();
      checks++;
      if (count !== exp[W+1:2]) begin
        failures++;
        $display("FAIL count: got %b expected %b", count, exp[W+1:2]);
      end
      checks++;
      if (wrap !== exp[1]) begin
        failures++;
        $display("FAIL wrap: got %b expected %b (count %b)", wrap, exp[1], count);
      end
      checks++;
      if (illegal !== exp[0]) begin
        failures++;
        $display("FAIL illegal: got %b expected %b (count %b)", illegal, exp[0], count);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic md;
    m_count = '0;

    // Reset, then ring left: 0001 0010 0100 1000 0001(wrap)
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0);

    // Johnson left: full period of 8 from reset
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, '0);

    // Ring reversed from 0001, then dir back to 0 at 0100
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, '0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, '0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, '0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0);

    // Load illegal ring seed with en high, then correction, then normal step
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0110);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0);

    // Johnson 0011, switch to ring mode (corrects to 0001), then hold 3 edges
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0011);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);

    // Reset mid-run while load and en are high, in both modes, then resume
    for (int m = 0; m < 2; m++) begin
      md = (m == 1);
      for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b1, md, 1'b0, '0);
      drive(1'b0, 1'b1, 1'b1, md, 1'b0, 4'b1010);
      for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b1, md, 1'b0, '0);
    end

    // Johnson right full period, wrap on return to 0000
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, '0);
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, '0);

    // Randomized: rare reset and load, frequent stepping, occasional mode flips
    md = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) md = ~md;
      drive(($urandom_range(0, 31) != 0),
            ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 3) != 0),
            md,
            1'($urandom_range(0, 1)),
            W'($urandom));
    end

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
